// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver and downstream key decode.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam logic [7:0] KEY_W = 8'h1D;
    localparam logic [7:0] KEY_A = 8'h1C;
    localparam logic [7:0] KEY_S = 8'h1B;
    localparam logic [7:0] KEY_D = 8'h23;

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes raw PS/2 clock/data, debounces the clock and strobes its filtered falling edge.
module ps2_line_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_clk,
    input  logic raw_data,
    output logic data_s,
    output logic fall
);

    localparam int unsigned CntW = $clog2(FILT_LEN + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   filt_q, filt_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   clk_s;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], raw_clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], raw_data};
        filt_d      = filt_q;
        cnt_d       = '0;
        fall        = 1'b0;
        // Any agreeing sample restarts the run of disagreeing ones.
        if (clk_s != filt_q) begin
            if (cnt_q == CntW'(FILT_LEN - 1)) begin
                filt_d = clk_s;
                fall   = filt_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            filt_q      <= 1'b1;
            cnt_q       <= '0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_q      <= filt_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: rtl/ps2_scancode_receiver.sv
// PS/2 device-to-host receiver: deframes bytes, strips E0/F0 prefixes, strobes clean scan codes.
// Optional PS2_TIMEOUT_EN aborts a partial frame after TIMEOUT_CYC cycles without a clock edge.
module ps2_scancode_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    if (SYNC_STAGES < 2 || FILT_LEN < 1 || TIMEOUT_CYC < 2) begin : g_bad_params
        $error("ps2_scancode_receiver: illegal parameter value");
    end

    logic data_s, fall;

    ps2_line_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_line_filter (
        .clk     (clk),
        .rst     (rst),
        .raw_clk (ps2_clk),
        .raw_data(ps2_data),
        .data_s  (data_s),
        .fall    (fall)
    );

    ps2_state_t state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       parity_q, parity_d;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [7:0] code_q, code_d;
    logic       is_break_q, is_break_d;
    logic       is_ext_q, is_ext_d;
    logic       code_valid_q, code_valid_d;
    logic       parity_err_q, parity_err_d;
    logic       frame_err_q, frame_err_d;
    logic       busy_q, busy_d;

`ifdef PS2_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
    logic [TmoW-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        ext_d        = ext_q;
        brk_d        = brk_q;
        code_d       = code_q;
        is_break_d   = is_break_q;
        is_ext_d     = is_ext_q;
        code_valid_d = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;

        if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!data_s) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d = {data_s, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d   = PARITY;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                PARITY: begin
                    parity_d = data_s;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!data_s) begin
                        frame_err_d = 1'b1;
                        ext_d       = 1'b0;
                        brk_d       = 1'b0;
                    end else if (^{shift_q, parity_q} != 1'b1) begin
                        parity_err_d = 1'b1;
                        ext_d        = 1'b0;
                        brk_d        = 1'b0;
                    end else if (shift_q == PS2_EXT) begin
                        ext_d = 1'b1;
                    end else if (shift_q == PS2_BRK) begin
                        brk_d = 1'b1;
                    end else begin
                        code_d       = shift_q;
                        is_ext_d     = ext_q;
                        is_break_d   = brk_q;
                        code_valid_d = 1'b1;
                        ext_d        = 1'b0;
                        brk_d        = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

`ifdef PS2_TIMEOUT_EN
        tmo_d = (fall || state_q == IDLE) ? '0 : tmo_q + 1'b1;
        // Abort on the cycle the counter would reach TIMEOUT_CYC; fall takes precedence.
        if (state_q != IDLE && !fall && tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
            bit_cnt_d   = '0;
            tmo_d       = '0;
        end
`endif

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            code_q       <= '0;
            is_break_q   <= 1'b0;
            is_ext_q     <= 1'b0;
            code_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            code_q       <= code_d;
            is_break_q   <= is_break_d;
            is_ext_q     <= is_ext_d;
            code_valid_q <= code_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

`ifdef PS2_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign code        = code_q;
    assign code_valid  = code_valid_q;
    assign is_break    = is_break_q;
    assign is_extended = is_ext_q;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Directed self-checking bench for ps2_scancode_receiver (define PS2_TIMEOUT_EN to cover the timeout).
module tb_ps2_scancode_receiver;
    import ps2_pkg::*;

    localparam int unsigned HalfBit = 20;
    localparam int unsigned TmoCyc  = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code;
    logic       code_valid, is_break, is_extended, parity_err, frame_err, busy;

    int checks = 0;
    int errors = 0;
    int n_valid = 0, n_perr = 0, n_ferr = 0, n_busy = 0, n_overlap = 0;
    int v0, p0, f0, b0;

    ps2_scancode_receiver #(
        .SYNC_STAGES(2),
        .FILT_LEN   (8),
        .TIMEOUT_CYC(TmoCyc)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code       (code),
        .code_valid (code_valid),
        .is_break   (is_break),
        .is_extended(is_extended),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    // Pulse/level monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (code_valid) n_valid++;
        if (parity_err) n_perr++;
        if (frame_err) n_ferr++;
        if (busy) n_busy++;
        if (int'(code_valid) + int'(parity_err) + int'(frame_err) > 1) n_overlap++;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        @(negedge clk);
        v0 = n_valid;
        p0 = n_perr;
        f0 = n_ferr;
        b0 = n_busy;
    endtask

    // Drives the first nbits of an 11-bit frame: start, 8 data LSB-first, odd parity, stop.
    task automatic send_bits(input logic [7:0] b, input logic par_flip, input logic stop_bit,
                             input int nbits);
        logic [10:0] bits;
        bits = {stop_bit, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_cycles(HalfBit);
            ps2_clk = 1'b0;
            wait_cycles(HalfBit);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_bit);
        send_bits(b, par_flip, stop_bit, 11);
        wait_cycles(2 * HalfBit);
        ps2_data = 1'b1;
    endtask

    initial begin
        wait_cycles(3);
        @(negedge clk);
        check("reset_code", 32'(code), 32'h00);
        check("reset_valid", 32'(code_valid), 0);
        check("reset_break", 32'(is_break), 0);
        check("reset_ext", 32'(is_extended), 0);
        check("reset_errs", 32'({parity_err, frame_err}), 0);
        check("reset_busy", 32'(busy), 0);
        rst = 1'b0;
        wait_cycles(5);

        // Plain make code
        snap();
        send_frame(KEY_W, 1'b0, 1'b1);
        @(negedge clk);
        check("w_valid_cnt", 32'(n_valid - v0), 1);
        check("w_code", 32'(code), 32'h1D);
        check("w_flags", 32'({is_extended, is_break}), 0);
        check("w_idle", 32'(busy), 0);

        // Break prefix: no strobe after F0 alone
        snap();
        send_frame(PS2_BRK, 1'b0, 1'b1);
        @(negedge clk);
        check("f0_no_strobe", 32'(n_valid - v0), 0);
        check("f0_code_held", 32'(code), 32'h1D);
        send_frame(KEY_A, 1'b0, 1'b1);
        @(negedge clk);
        check("a_brk_valid_cnt", 32'(n_valid - v0), 1);
        check("a_brk_code", 32'(code), 32'h1C);
        check("a_brk_flags", 32'({is_extended, is_break}), 32'b01);

        // Extended break, then a plain code clears both flags
        snap();
        send_frame(PS2_EXT, 1'b0, 1'b1);
        send_frame(PS2_BRK, 1'b0, 1'b1);
        send_frame(KEY_D, 1'b0, 1'b1);
        @(negedge clk);
        check("d_ext_brk_valid_cnt", 32'(n_valid - v0), 1);
        check("d_ext_brk_code", 32'(code), 32'h23);
        check("d_ext_brk_flags", 32'({is_extended, is_break}), 32'b11);
        send_frame(KEY_S, 1'b0, 1'b1);
        @(negedge clk);
        check("s_code", 32'(code), 32'h1B);
        check("s_flags", 32'({is_extended, is_break}), 0);

        // Repeated prefix is idempotent
        snap();
        send_frame(PS2_EXT, 1'b0, 1'b1);
        send_frame(PS2_EXT, 1'b0, 1'b1);
        send_frame(KEY_W, 1'b0, 1'b1);
        @(negedge clk);
        check("ee_valid_cnt", 32'(n_valid - v0), 1);
        check("ee_flags", 32'({is_extended, is_break}), 32'b10);

        // Parity error after E0: discarded, flags cleared, code held
        snap();
        send_frame(PS2_EXT, 1'b0, 1'b1);
        send_frame(KEY_S, 1'b1, 1'b1);
        @(negedge clk);
        check("par_perr_cnt", 32'(n_perr - p0), 1);
        check("par_no_valid", 32'(n_valid - v0), 0);
        check("par_code_held", 32'(code), 32'h1D);
        send_frame(KEY_D, 1'b0, 1'b1);
        @(negedge clk);
        check("after_par_code", 32'(code), 32'h23);
        check("after_par_flags", 32'({is_extended, is_break}), 0);

        // Stop bit low: frame_err only
        snap();
        send_frame(KEY_A, 1'b0, 1'b0);
        @(negedge clk);
        check("stop_ferr_cnt", 32'(n_ferr - f0), 1);
        check("stop_perr_cnt", 32'(n_perr - p0), 0);
        check("stop_no_valid", 32'(n_valid - v0), 0);
        check("stop_code_held", 32'(code), 32'h23);

        // Short clock glitches must not register as edges
        snap();
        for (int k = 0; k < 6; k++) begin
            ps2_data = 1'b0;
            ps2_clk  = 1'b0;
            wait_cycles(3);
            ps2_clk = 1'b1;
            wait_cycles(15);
        end
        ps2_data = 1'b1;
        wait_cycles(20);
        @(negedge clk);
        check("glitch_busy_cycles", 32'(n_busy - b0), 0);
        send_frame(KEY_S, 1'b0, 1'b1);
        @(negedge clk);
        check("post_glitch_code", 32'(code), 32'h1B);
        check("post_glitch_valid_cnt", 32'(n_valid - v0), 1);

        // Reset mid-frame: start + 4 data bits, then reset
        send_bits(KEY_W, 1'b0, 1'b1, 5);
        wait_cycles(HalfBit);
        @(negedge clk);
        check("mid_frame_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("rst_async_busy", 32'(busy), 0);
        check("rst_async_code", 32'(code), 0);
        wait_cycles(3);
        ps2_data = 1'b1;
        rst = 1'b0;
        wait_cycles(10);
        snap();
        send_frame(KEY_A, 1'b0, 1'b1);
        @(negedge clk);
        check("post_rst_code", 32'(code), 32'h1C);
        check("post_rst_valid_cnt", 32'(n_valid - v0), 1);
        check("post_rst_flags", 32'({is_extended, is_break}), 0);

`ifdef PS2_TIMEOUT_EN
        // Partial frame then silence
        snap();
        send_bits(KEY_D, 1'b0, 1'b1, 5);
        ps2_data = 1'b1;
        wait_cycles(TmoCyc / 2);
        @(negedge clk);
        check("tmo_still_busy", 32'(busy), 1);
        check("tmo_not_yet", 32'(n_ferr - f0), 0);
        wait_cycles(TmoCyc);
        @(negedge clk);
        check("tmo_ferr_cnt", 32'(n_ferr - f0), 1);
        check("tmo_busy_fell", 32'(busy), 0);
        check("tmo_code_held", 32'(code), 32'h1C);
        send_frame(KEY_W, 1'b0, 1'b1);
        @(negedge clk);
        check("post_tmo_code", 32'(code), 32'h1D);
`endif

        check("pulse_overlap", 32'(n_overlap), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute guard against a hung run.
    initial begin
        #20ms;
        $display("FAIL timeout: simulation did not complete, observed hang, required finish");
        $fatal(1, "bench time limit expired");
    end

endmodule
